// File: rtl/imem_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Also sizes the instruction memory itself.
package imem_pkg;

    localparam int IMEM_BYTES = 128;
    localparam int LEN_BYTES  = 2;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        CHECK_LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: length/payload/checksum byte stream into instruction memory.
// Keeps the core in reset until a verified image is in place.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_resetn,
    output logic              load_done,
    output logic              load_error
);

    ld_state_e   state;
    ld_state_e   state_nx;
    logic [15:0] len_q;
    logic [15:0] count_q;
    logic [7:0]  csum_q;
    logic        ready_st;
    logic        done_st;
    logic        err_st;
    logic        xfer;
    logic        len_bad;
    logic        last_byte;

    assign xfer      = rx_valid && rx_ready;
    assign len_bad   = (len_q > 16'(MEM_BYTES)) || (len_q[1:0] != 2'b00);
    assign last_byte = (count_q == len_q - 16'd1);

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= LEN_HI;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready_st = 1'b0;
        done_st  = 1'b0;
        err_st   = 1'b0;
        unique case (state)
            LEN_HI: begin
                ready_st = 1'b1;
                if (rx_valid)
                    state_nx = LEN_LO;
            end
            LEN_LO: begin
                ready_st = 1'b1;
                if (rx_valid)
                    state_nx = CHECK_LEN;
            end
            CHECK_LEN: begin
                if (len_bad)
                    state_nx = ERROR;
                else if (len_q == 16'd0)
                    state_nx = CSUM;
                else
                    state_nx = DATA;
            end
            DATA: begin
                ready_st = 1'b1;
                if (rx_valid && last_byte)
                    state_nx = CSUM;
            end
            CSUM: begin
                ready_st = 1'b1;
                if (rx_valid)
                    state_nx = (rx_data == csum_q) ? DONE : ERROR;
            end
            DONE: begin
                done_st = 1'b1;
            end
            ERROR: begin
                err_st = 1'b1;
            end
            default: begin
                state_nx = LEN_HI;
            end
        endcase
    end

    // Status outputs are gated so they drop as soon as resetn falls.
    assign rx_ready   = ready_st & resetn;
    assign load_done  = done_st & resetn;
    assign cpu_resetn = done_st & resetn;
    assign load_error = err_st & resetn;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            len_q     <= '0;
            count_q   <= '0;
            csum_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state == CHECK_LEN) begin
                count_q <= '0;
                csum_q  <= '0;
            end
            if (xfer) begin
                unique case (state)
                    LEN_HI: len_q[15:8] <= rx_data;
                    LEN_LO: len_q[7:0]  <= rx_data;
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'(count_q);
                        mem_wdata <= rx_data;
                        csum_q    <= csum_q ^ rx_data;
                        count_q   <= count_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level model.
// Compares every output on each falling edge.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_resetn;
    logic        load_done;
    logic        load_error;

    always #5 clk = ~clk;

    imem_loader #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk(clk),
        .resetn(resetn),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_resetn(cpu_resetn),
        .load_done(load_done),
        .load_error(load_error)
    );

    int checks = 0;
    int failures = 0;
    int nwr = 0;
    logic [7:0] tmem [128];
    logic [7:0] fr [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: 0 loading, 1 done, 2 error
    logic        started = 1'b0;
    int          m_st;
    int          m_pos;
    logic        m_chk;
    int          m_len;
    logic [7:0]  m_x;
    logic        m_we;
    logic [31:0] m_addr;
    logic [7:0]  m_wd;

    always @(posedge clk) begin
        started <= 1'b1;
        if (!resetn) begin
            m_st <= 0; m_pos <= 0; m_chk <= 1'b0; m_len <= 0;
            m_x <= 8'h00; m_we <= 1'b0; m_addr <= 32'h0; m_wd <= 8'h00;
        end else begin
            m_we <= 1'b0;
            if (m_chk) begin
                m_chk <= 1'b0;
                if (m_len > 128 || m_len % 4 != 0)
                    m_st <= 2;
            end else if (m_st == 0 && rx_valid) begin
                if (m_pos == 0) begin
                    m_len <= int'(rx_data) * 256;
                    m_pos <= 1;
                end else if (m_pos == 1) begin
                    m_len <= m_len + int'(rx_data);
                    m_pos <= 2;
                    m_chk <= 1'b1;
                end else if (m_pos - 2 < m_len) begin
                    m_we   <= 1'b1;
                    m_addr <= 32'(m_pos - 2);
                    m_wd   <= rx_data;
                    m_x    <= m_x ^ rx_data;
                    m_pos  <= m_pos + 1;
                end else begin
                    m_st <= (rx_data == m_x) ? 1 : 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rx_ready", 32'(rx_ready), 32'(resetn && m_st == 0 && !m_chk));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", mem_addr, m_addr);
            if (m_we)
                chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
            chk("load_done", 32'(load_done), 32'(resetn && m_st == 1));
            chk("load_error", 32'(load_error), 32'(resetn && m_st == 2));
            chk("cpu_resetn", 32'(cpu_resetn), 32'(resetn && m_st == 1));
            if (mem_we) begin
                tmem[mem_addr[6:0]] = mem_wdata;
                nwr++;
            end
        end
    end

    // mode 0: always valid, 1: pattern 1,0,0, 2: random
    task automatic send(input int nacc, input int mode);
        int idx = 0;
        int cyc = 0;
        logic acc;
        logic v;
        while (idx < nacc && cyc < 600) begin
            if (mode == 0)
                v = 1'b1;
            else if (mode == 1)
                v = (cyc % 3 == 0);
            else
                v = ($urandom_range(0, 2) != 0);
            rx_valid = v;
            rx_data = (v && idx < fr.size()) ? fr[idx] : 8'($urandom);
            @(negedge clk);
            acc = rx_valid && rx_ready;
            @(posedge clk);
            #1;
            if (acc)
                idx++;
            cyc++;
        end
        rx_valid = 1'b0;
        if (idx < nacc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=%0d required=%0d", idx, nacc);
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic junk(input int n);
        repeat (n) begin
            rx_valid = 1'b1;
            rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic nominal(input logic [7:0] cs);
        fr = {8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'hF0, 8'h00, 8'h93, cs};
    endtask

    initial begin
        int base;
        int len;
        logic bad;
        logic corrupt;
        logic [7:0] x;
        logic [15:0] l16;
        resetn = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cpu_resetn", 32'(cpu_resetn), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        resetn = 1'b1;
        #1;
        chk("reset_rx_ready", 32'(rx_ready), 32'h1);

        // nominal load
        nominal(8'h63);
        base = nwr;
        send(11, 0);
        idle(3);
        chk("nom_writes", 32'(nwr - base), 32'd8);
        chk("nom_done", 32'(load_done), 32'h1);
        chk("nom_cpu_resetn", 32'(cpu_resetn), 32'h1);
        chk("nom_mem5", 32'(tmem[5]), 32'hF0);
        chk("nom_mem7", 32'(tmem[7]), 32'h93);

        // checksum mismatch
        do_reset();
        nominal(8'h62);
        base = nwr;
        send(11, 0);
        junk(4);
        chk("csum_writes", 32'(nwr - base), 32'd8);
        chk("csum_error", 32'(load_error), 32'h1);
        chk("csum_cpu_resetn", 32'(cpu_resetn), 32'h0);
        chk("csum_rx_ready", 32'(rx_ready), 32'h0);

        // bad lengths
        for (int i = 0; i < 2; i++) begin
            do_reset();
            fr = {8'h00, (i == 0) ? 8'h06 : 8'h84};
            base = nwr;
            send(2, 0);
            chk("badlen_pre", 32'(load_error), 32'h0);
            @(posedge clk);
            #1;
            chk("badlen_err", 32'(load_error), 32'h1);
            junk(3);
            chk("badlen_writes", 32'(nwr - base), 32'd0);
        end

        // throttled
        do_reset();
        nominal(8'h63);
        tmem[5] = 8'h00;
        base = nwr;
        send(11, 1);
        idle(3);
        chk("thr_writes", 32'(nwr - base), 32'd8);
        chk("thr_mem5", 32'(tmem[5]), 32'hF0);
        chk("thr_done", 32'(load_done), 32'h1);

        // zero length
        do_reset();
        fr = {8'h00, 8'h00, 8'h00};
        base = nwr;
        send(3, 0);
        idle(2);
        chk("zero_writes", 32'(nwr - base), 32'd0);
        chk("zero_done", 32'(load_done), 32'h1);

        // reset mid-load
        do_reset();
        nominal(8'h63);
        base = nwr;
        send(5, 0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rx_ready", 32'(rx_ready), 32'h0);
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        resetn = 1'b1;
        send(11, 0);
        idle(3);
        chk("midrst_writes", 32'(nwr - base), 32'd11);
        chk("midrst_done", 32'(load_done), 32'h1);

        // random frames
        repeat (25) begin
            do_reset();
            bad = ($urandom_range(0, 7) == 0);
            corrupt = ($urandom_range(0, 3) == 0);
            if (bad)
                len = ($urandom_range(0, 1) == 1) ? 4 * $urandom_range(33, 16383)
                                                  : 4 * $urandom_range(0, 32) + $urandom_range(1, 3);
            else
                len = 4 * $urandom_range(0, 32);
            l16 = 16'(len);
            fr.delete();
            fr.push_back(l16[15:8]);
            fr.push_back(l16[7:0]);
            x = 8'h00;
            if (!bad) begin
                for (int k = 0; k < len; k++) begin
                    fr.push_back(8'($urandom));
                    x = x ^ fr[k + 2];
                end
                fr.push_back(corrupt ? ~x : x);
            end
            base = nwr;
            send(bad ? 2 : len + 3, 2);
            idle(2);
            junk(3);
            chk("rnd_writes", 32'(nwr - base), bad ? 32'd0 : 32'(len));
            chk("rnd_done", 32'(load_done), 32'(!bad && !corrupt));
            chk("rnd_error", 32'(load_error), 32'(bad || corrupt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
